// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier.
// Define ALU_MUL_EN to build the multiplier; otherwise op 111 completes at once and is flagged illegal.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSlt = 3'b101;
  localparam logic [2:0] OpSll = 3'b110;
`ifdef ALU_MUL_EN
  localparam logic [2:0] OpMul = 3'b111;
`endif

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf, alu_ill;

  logic [WIDTH-1:0] result_q;
  logic             done_q, zero_q, ovf_q, illegal_q;

  always_comb begin
    sum     = a + b;
    diff    = a - b;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OpAdd: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpXor:   alu_res = a ^ b;
      OpSlt:   alu_res[0] = ($signed(a) < $signed(b));
      OpSll:   alu_res = a << b[2:0];
      default: begin
`ifndef ALU_MUL_EN
        alu_ill = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic {StIdle, StMul} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
  logic [WIDTH-1:0]   mplier_q;

  always_comb begin
    acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  assign busy = (state_q == StMul);
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      done_q    <= 1'b0;
      zero_q    <= 1'b1;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef ALU_MUL_EN
      if (state_q == StMul) begin
        // start is ignored here; the last iteration writes straight from acc_d
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          result_q  <= acc_d[WIDTH-1:0];
          zero_q    <= (acc_d[WIDTH-1:0] == '0);
          ovf_q     <= |acc_d[2*WIDTH-1:WIDTH];
          illegal_q <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= StIdle;
        end
      end else if (start && (op == OpMul)) begin
        mcand_q  <= {{WIDTH{1'b0}}, a};
        mplier_q <= b;
        acc_q    <= '0;
        cnt_q    <= CntW'(WIDTH);
        state_q  <= StMul;
      end else
`endif
      if (start) begin
        result_q  <= alu_res;
        zero_q    <= (alu_res == '0);
        ovf_q     <= alu_ovf;
        illegal_q <= alu_ill;
        done_q    <= 1'b1;
      end
    end
  end

  assign result  = result_q;
  assign done    = done_q;
  assign zero    = zero_q;
  assign ovf     = ovf_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage; MUL scenarios build only with ALU_MUL_EN.
module tb_alu_exec_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, zero, ovf, illegal;
  logic [7:0] result;

  int total = 0;
  int passed = 0;

  alu_exec_stage #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .ovf     (ovf),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Drive one start on the next rising edge and return 1ns after that edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, result, zero, ovf, illegal} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_state: got b%0b d%0b r%02h z%0b o%0b i%0b want b0 d0 r00 z1 o0 i0",
               busy, done, result, zero, ovf, illegal);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    issue(3'b000, 8'h7F, 8'h01);
    total++;
    if ({done, result, zero, ovf, illegal} !== {1'b1, 8'h80, 1'b0, 1'b1, 1'b0})
      $display("FAIL add_ovf: got d%0b r%02h z%0b o%0b i%0b want d1 r80 z0 o1 i0",
               done, result, zero, ovf, illegal);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if ({done, result} !== {1'b0, 8'h80})
      $display("FAIL add_done_pulse: got d%0b r%02h want d0 r80", done, result);
    else passed++;
  endtask

  task automatic test_logic_ops;
    issue(3'b001, 8'h05, 8'h05);
    total++;
    if ({result, zero, ovf} !== {8'h00, 1'b1, 1'b0})
      $display("FAIL sub_zero: got r%02h z%0b o%0b want r00 z1 o0", result, zero, ovf);
    else passed++;
    issue(3'b101, 8'hFF, 8'h01);
    total++;
    if ({result, zero} !== {8'h01, 1'b0})
      $display("FAIL slt_signed: got r%02h z%0b want r01 z0", result, zero);
    else passed++;
    issue(3'b110, 8'h81, 8'h09);
    total++;
    if (result !== 8'h02) $display("FAIL sll_low3: got r%02h want r02", result);
    else passed++;
    issue(3'b001, 8'h80, 8'h01);
    total++;
    if ({result, ovf} !== {8'h7F, 1'b1})
      $display("FAIL sub_ovf: got r%02h o%0b want r7F o1", result, ovf);
    else passed++;
    issue(3'b010, 8'hF0, 8'h3C);
    total++;
    if (result !== 8'h30) $display("FAIL and: got r%02h want r30", result);
    else passed++;
    issue(3'b100, 8'hA5, 8'hFF);
    total++;
    if ({result, ovf} !== {8'h5A, 1'b0})
      $display("FAIL xor: got r%02h o%0b want r5A o0", result, ovf);
    else passed++;
    issue(3'b101, 8'h01, 8'hFF);
    total++;
    if ({result, zero} !== {8'h00, 1'b1})
      $display("FAIL slt_false: got r%02h z%0b want r00 z1", result, zero);
    else passed++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 8'h01; b = 8'h02;
    @(posedge clk);
    #1;
    total++;
    if ({done, result} !== {1'b1, 8'h03})
      $display("FAIL b2b_first: got d%0b r%02h want d1 r03", done, result);
    else passed++;
    @(negedge clk);
    a = 8'h03; b = 8'h04;
    @(posedge clk);
    #1;
    total++;
    if ({done, result} !== {1'b1, 8'h07})
      $display("FAIL b2b_second: got d%0b r%02h want d1 r07", done, result);
    else passed++;
    start = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) $display("FAIL b2b_done_fall: got d%0b want d0", done);
    else passed++;
  endtask

  task automatic test_async_reset;
    issue(3'b000, 8'h7F, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, result, zero, ovf, illegal} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0})
      $display("FAIL async_reset: got b%0b d%0b r%02h z%0b o%0b i%0b want b0 d0 r00 z1 o0 i0",
               busy, done, result, zero, ovf, illegal);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul;
    int bad;
    issue(3'b111, 8'h0C, 8'h0B);
    bad = (busy !== 1'b1 || done !== 1'b0) ? 1 : 0;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL mul_busy_window: got %0d bad cycles want 0", bad);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if ({busy, done, result, zero, ovf, illegal} !== {1'b0, 1'b1, 8'h84, 1'b0, 1'b0, 1'b0})
      $display("FAIL mul_0c_0b: got b%0b d%0b r%02h z%0b o%0b i%0b want b0 d1 r84 z0 o0 i0",
               busy, done, result, zero, ovf, illegal);
    else passed++;
    issue(3'b111, 8'h10, 8'h10);
    repeat (8) @(posedge clk);
    #1;
    total++;
    if ({done, result, zero, ovf} !== {1'b1, 8'h00, 1'b1, 1'b1})
      $display("FAIL mul_10_10: got d%0b r%02h z%0b o%0b want d1 r00 z1 o1",
               done, result, zero, ovf);
    else passed++;
  endtask

  task automatic test_mul_ignore_start;
    int dones;
    int done_at;
    dones = 0;
    done_at = 0;
    issue(3'b111, 8'h03, 8'h05);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = (i == 2 || i == 8);
      op = 3'b000; a = 8'h01; b = 8'h01;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        done_at = i;
      end
    end
    total++;
    if (dones != 1 || done_at != 8)
      $display("FAIL mul_ignore_done: got %0d pulses last at %0d want 1 at 8", dones, done_at);
    else passed++;
    total++;
    if ({busy, result} !== {1'b0, 8'h0F})
      $display("FAIL mul_ignore_result: got b%0b r%02h want b0 r0F", busy, result);
    else passed++;
  endtask

  task automatic test_mul_reset_abort;
    int dones;
    dones = 0;
    issue(3'b111, 8'h0C, 8'h0B);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, result, zero, ovf} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0})
      $display("FAIL mul_abort_reset: got b%0b d%0b r%02h z%0b o%0b want b0 d0 r00 z1 o0",
               busy, done, result, zero, ovf);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    total++;
    if (dones != 0) $display("FAIL mul_abort_quiet: got %0d active cycles want 0", dones);
    else passed++;
    issue(3'b000, 8'h02, 8'h03);
    total++;
    if ({done, result} !== {1'b1, 8'h05})
      $display("FAIL mul_abort_add: got d%0b r%02h want d1 r05", done, result);
    else passed++;
  endtask
`else
  task automatic test_illegal;
    int busy_seen;
    issue(3'b111, 8'h0C, 8'h0B);
    busy_seen = (busy !== 1'b0) ? 1 : 0;
    total++;
    if ({done, result, zero, ovf, illegal} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b1})
      $display("FAIL illegal_mul: got d%0b r%02h z%0b o%0b i%0b want d1 r00 z1 o0 i1",
               done, result, zero, ovf, illegal);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0) busy_seen++;
    end
    total++;
    if ({busy_seen != 0, done, illegal} !== {1'b0, 1'b0, 1'b1})
      $display("FAIL illegal_hold: got busy_cycles %0d d%0b i%0b want 0 d0 i1",
               busy_seen, done, illegal);
    else passed++;
    issue(3'b011, 8'hF0, 8'h0F);
    total++;
    if ({done, result, zero, illegal} !== {1'b1, 8'hFF, 1'b0, 1'b0})
      $display("FAIL illegal_clear_or: got d%0b r%02h z%0b i%0b want d1 rFF z0 i0",
               done, result, zero, illegal);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_logic_ops();
    test_back_to_back();
    test_async_reset();
`ifdef ALU_MUL_EN
    test_mul();
    test_mul_ignore_start();
    test_mul_reset_abort();
`else
    test_illegal();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
